fwd_scoreboard: RTL and testbench

- Parametrised forwarding and hazard unit for the multi-issue in-order RISC-V core.
- Tracks destination registers of in-flight producers in an internal shift pipeline (stage 0 = EX, increasing index = older stage).
- For every source operand in the decode bundle, produces a forwarding-select code.
- Detects load-use and intra-bundle hazards, drives stall and issue masks, and counts stall cycles.

---
 rtl/fwd_pkg.sv | 19 +
 rtl/fwd_match.sv | 49 ++++
 rtl/fwd_scoreboard.sv | 118 +++++++++++
 tb/tb_fwd_scoreboard.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Shared record type and select-code helpers for the forwarding scoreboard.
package fwd_pkg;

    // Record dst field is sized for the widest supported register number;
    // narrower REGW values are zero-extended on entry.
    localparam int MAX_REGW = 8;
    localparam int SEL_RF   = 32'sd0;

    typedef struct packed {
        logic                valid;
        logic [MAX_REGW-1:0] dst;
        logic                is_load;
    } fwd_rec_t;

    function automatic int sel_encode(input int stage, input int lane, input int lanes);
        return 32'sd1 + stage * lanes + lane;
    endfunction

endpackage

// File: rtl/fwd_match.sv
// Priority search of all in-flight producer records for one source operand.
module fwd_match
    import fwd_pkg::*;
#(
    parameter int LANES      = 2,
    parameter int NSTAGES    = 3,
    parameter int LOAD_STAGE = 1,
    parameter int REGW       = 5,
    parameter int SELW       = $clog2(NSTAGES * LANES + 1)
) (
    input  logic [REGW-1:0]                src_i,
    input  fwd_rec_t [NSTAGES*LANES-1:0]   recs_i,
    output logic [SELW-1:0]                sel_o,
    output logic                           load_not_ready_o
);

    localparam int NREC = NSTAGES * LANES;

    logic [MAX_REGW-1:0] src_x_s;
    logic [NREC-1:0]     hit_s;

    assign src_x_s = MAX_REGW'(src_i);

    // Raw per-record match; x0 never forwards.
    always_comb begin
        hit_s = '0;
        for (int i = 0; i < NREC; i++) begin
            hit_s[i] = recs_i[i].valid & (recs_i[i].dst == src_x_s) & (src_x_s != '0);
        end
    end

    // Oldest stage first, lowest lane first, so the last hit seen is the youngest producer.
    always_comb begin
        sel_o            = SELW'(SEL_RF);
        load_not_ready_o = 1'b0;
        for (int s = NSTAGES - 1; s >= 0; s--) begin
            for (int l = 0; l < LANES; l++) begin
                if (hit_s[s*LANES + l]) begin
                    sel_o            = SELW'(sel_encode(s, l, LANES));
                    load_not_ready_o = recs_i[s*LANES + l].is_load & (s < LOAD_STAGE);
                end else begin
                    sel_o            = sel_o;
                    load_not_ready_o = load_not_ready_o;
                end
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding/hazard unit: producer record pipeline, per-operand forward selects,
// intra-bundle issue masking, load-use stall and saturating stall counter.
module fwd_scoreboard
    import fwd_pkg::*;
#(
    parameter int LANES      = 2,
    parameter int NSTAGES    = 3,
    parameter int LOAD_STAGE = 1,
    parameter int REGW       = 5,
    parameter int SELW       = $clog2(NSTAGES * LANES + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [LANES-1:0]        dec_valid,
    input  logic [LANES*REGW-1:0]   dec_src1,
    input  logic [LANES*REGW-1:0]   dec_src2,
    input  logic [LANES*REGW-1:0]   dec_dst,
    input  logic [LANES-1:0]        dec_we,
    input  logic [LANES-1:0]        dec_is_load,
    input  logic                    pipe_hold,
    input  logic                    flush,
    output logic [LANES*SELW-1:0]   fwd_sel1,
    output logic [LANES*SELW-1:0]   fwd_sel2,
    output logic [LANES-1:0]        issue_mask,
    output logic                    stall_out,
    output logic [31:0]             stall_cycles
);

    localparam int NREC = NSTAGES * LANES;

    fwd_rec_t [NREC-1:0] recs_q, recs_d;
    logic [31:0]         stall_cnt_q, stall_cnt_d;
    logic [LANES-1:0]    lnr1_s, lnr2_s;
    logic [LANES-1:0]    mask_s;
    logic                stall_s;
    logic                block_s;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        fwd_match #(
            .LANES(LANES), .NSTAGES(NSTAGES), .LOAD_STAGE(LOAD_STAGE),
            .REGW(REGW), .SELW(SELW)
        ) u_match1 (
            .src_i            (dec_src1[g*REGW +: REGW]),
            .recs_i           (recs_q),
            .sel_o            (fwd_sel1[g*SELW +: SELW]),
            .load_not_ready_o (lnr1_s[g])
        );
        fwd_match #(
            .LANES(LANES), .NSTAGES(NSTAGES), .LOAD_STAGE(LOAD_STAGE),
            .REGW(REGW), .SELW(SELW)
        ) u_match2 (
            .src_i            (dec_src2[g*REGW +: REGW]),
            .recs_i           (recs_q),
            .sel_o            (fwd_sel2[g*SELW +: SELW]),
            .load_not_ready_o (lnr2_s[g])
        );
    end

    // A lane reading an older lane's rd in the same bundle blocks itself and every later lane.
    always_comb begin
        block_s = 1'b0;
        mask_s  = '0;
        for (int j = 0; j < LANES; j++) begin
            for (int i = 0; i < j; i++) begin
                block_s = block_s
                        | (dec_valid[i] & dec_we[i] & (dec_dst[i*REGW +: REGW] != '0)
                           & ((dec_src1[j*REGW +: REGW] == dec_dst[i*REGW +: REGW])
                            | (dec_src2[j*REGW +: REGW] == dec_dst[i*REGW +: REGW])));
            end
            mask_s[j] = dec_valid[j] & ~block_s;
        end
    end

    assign stall_s      = |(mask_s & (lnr1_s | lnr2_s));
    assign issue_mask   = mask_s;
    assign stall_out    = stall_s;
    assign stall_cycles = stall_cnt_q;

    // Record advance: hold freezes everything, otherwise shift and load stage 0.
    always_comb begin
        recs_d      = recs_q;
        stall_cnt_d = stall_cnt_q;
        if (pipe_hold) begin
            recs_d      = recs_q;
            stall_cnt_d = stall_cnt_q;
        end else begin
            for (int i = LANES; i < NREC; i++) begin
                recs_d[i] = recs_q[i - LANES];
            end
            for (int l = 0; l < LANES; l++) begin
                if (flush || stall_s) begin
                    recs_d[l] = '0;
                end else begin
                    recs_d[l].valid   = dec_valid[l] & mask_s[l] & dec_we[l];
                    recs_d[l].dst     = MAX_REGW'(dec_dst[l*REGW +: REGW]);
                    recs_d[l].is_load = dec_is_load[l];
                end
            end
            if (!flush && stall_s && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_d = stall_cnt_q + 32'd1;
            end else begin
                stall_cnt_d = stall_cnt_q;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            recs_q      <= '0;
            stall_cnt_q <= 32'd0;
        end else begin
            recs_q      <= recs_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard: behavioural model compared every cycle
// plus directed scenarios with hand-computed expectations.
module tb_fwd_scoreboard;

    localparam int L  = 2;
    localparam int NS = 3;
    localparam int LS = 1;
    localparam int RW = 5;
    localparam int SW = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic [L-1:0]    dec_valid, dec_we, dec_is_load;
    logic [L*RW-1:0] dec_src1, dec_src2, dec_dst;
    logic            pipe_hold, flush;
    logic [L*SW-1:0] fwd_sel1, fwd_sel2;
    logic [L-1:0]    issue_mask;
    logic            stall_out;
    logic [31:0]     stall_cycles;

    int cmp_count = 0;
    int err_count = 0;

    always #5 clk = ~clk;

    fwd_scoreboard #(.LANES(L), .NSTAGES(NS), .LOAD_STAGE(LS), .REGW(RW), .SELW(SW)) dut (
        .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_src1(dec_src1),
        .dec_src2(dec_src2), .dec_dst(dec_dst), .dec_we(dec_we), .dec_is_load(dec_is_load),
        .pipe_hold(pipe_hold), .flush(flush), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
        .issue_mask(issue_mask), .stall_out(stall_out), .stall_cycles(stall_cycles)
    );

    // Model: per stage/lane producer table plus stall count.
    bit     m_v  [NS][L];
    int     m_d  [NS][L];
    bit     m_ld [NS][L];
    longint m_cnt;
    bit     model_ok = 1'b0;

    function automatic int src_of(int which, int l);
        if (which == 1) return int'(dec_src1[l*RW +: RW]);
        return int'(dec_src2[l*RW +: RW]);
    endfunction

    function automatic int dst_of(int l);
        return int'(dec_dst[l*RW +: RW]);
    endfunction

    // Youngest producer: search from EX outward, later lane first.
    function automatic int exp_sel(int src);
        if (src == 0) return 0;
        for (int s = 0; s < NS; s++)
            for (int l = L - 1; l >= 0; l--)
                if (m_v[s][l] && m_d[s][l] == src) return 1 + s * L + l;
        return 0;
    endfunction

    function automatic bit exp_lnr(int src);
        if (src == 0) return 1'b0;
        for (int s = 0; s < NS; s++)
            for (int l = L - 1; l >= 0; l--)
                if (m_v[s][l] && m_d[s][l] == src) return m_ld[s][l] && (s < LS);
        return 1'b0;
    endfunction

    function automatic logic [L-1:0] exp_mask();
        logic [L-1:0] m;
        m = dec_valid;
        for (int j = 1; j < L; j++)
            for (int i = 0; i < j; i++)
                if (dec_valid[i] && dec_we[i] && dst_of(i) != 0 &&
                    (src_of(1, j) == dst_of(i) || src_of(2, j) == dst_of(i)))
                    for (int k = j; k < L; k++) m[k] = 1'b0;
        return m;
    endfunction

    function automatic bit exp_stall();
        logic [L-1:0] mk;
        mk = exp_mask();
        for (int l = 0; l < L; l++)
            if (mk[l] && (exp_lnr(src_of(1, l)) || exp_lnr(src_of(2, l)))) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step();
        bit           st;
        logic [L-1:0] mk;
        if (reset) begin
            for (int s = 0; s < NS; s++)
                for (int l = 0; l < L; l++) begin
                    m_v[s][l] = 1'b0; m_d[s][l] = 0; m_ld[s][l] = 1'b0;
                end
            m_cnt    = 0;
            model_ok = 1'b1;
        end else if (model_ok && !pipe_hold) begin
            st = exp_stall();
            mk = exp_mask();
            for (int s = NS - 1; s > 0; s--)
                for (int l = 0; l < L; l++) begin
                    m_v[s][l] = m_v[s-1][l]; m_d[s][l] = m_d[s-1][l]; m_ld[s][l] = m_ld[s-1][l];
                end
            for (int l = 0; l < L; l++) begin
                m_v[0][l]  = !flush && !st && dec_valid[l] && mk[l] && dec_we[l];
                m_d[0][l]  = dst_of(l);
                m_ld[0][l] = dec_is_load[l];
            end
            if (!flush && st && m_cnt < 64'hFFFF_FFFF) m_cnt++;
        end
    endtask

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        cmp_count++;
        if (act !== exp) begin
            err_count++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, away from the clock edge.
    always @(negedge clk) begin : compare
        if (model_ok) begin
            for (int l = 0; l < L; l++) begin
                check($sformatf("model sel1[%0d]", l), fwd_sel1[l*SW +: SW], exp_sel(src_of(1, l)));
                check($sformatf("model sel2[%0d]", l), fwd_sel2[l*SW +: SW], exp_sel(src_of(2, l)));
            end
            check("model issue_mask", issue_mask, exp_mask());
            check("model stall_out", stall_out, exp_stall());
            check("model stall_cycles", stall_cycles, m_cnt);
        end
    end

    task automatic idle();
        dec_valid = '0; dec_we = '0; dec_is_load = '0;
        dec_src1 = '0; dec_src2 = '0; dec_dst = '0;
    endtask

    task automatic set_lane(int l, bit v, int s1, int s2, int d, bit we, bit ld);
        dec_valid[l]          = v;
        dec_src1[l*RW +: RW]  = RW'(s1);
        dec_src2[l*RW +: RW]  = RW'(s2);
        dec_dst[l*RW +: RW]   = RW'(d);
        dec_we[l]             = we;
        dec_is_load[l]        = ld;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset = 1'b1; pipe_hold = 1'b0; flush = 1'b0;
        idle();
        cycle(); cycle();
        reset = 1'b0;

        // Reset state with a full non-writing bundle
        set_lane(0, 1, 3, 4, 0, 0, 0);
        set_lane(1, 1, 6, 7, 0, 0, 0);
        settle();
        check("rst sel1", fwd_sel1, 0);
        check("rst sel2", fwd_sel2, 0);
        check("rst mask", issue_mask, 2'b11);
        check("rst stall", stall_out, 0);
        check("rst count", stall_cycles, 0);

        // EX forward, then MEM forward
        idle(); set_lane(0, 1, 1, 2, 5, 1, 0);
        cycle();
        idle(); set_lane(1, 1, 5, 6, 0, 0, 0);
        settle();
        check("ex fwd sel1[1]", fwd_sel1[SW +: SW], 1);
        cycle(); settle();
        check("mem fwd sel1[1]", fwd_sel1[SW +: SW], 3);

        // Youngest wins
        idle(); set_lane(0, 1, 1, 2, 7, 1, 0);
        cycle();
        idle();
        cycle();
        idle(); set_lane(0, 1, 1, 2, 3, 0, 0); set_lane(1, 1, 1, 2, 7, 1, 0);
        cycle();
        idle(); set_lane(0, 1, 1, 7, 0, 0, 0);
        settle();
        check("youngest sel2[0]", fwd_sel2[0 +: SW], 2);
        cycle(); settle();
        check("youngest aged sel2[0]", fwd_sel2[0 +: SW], 4);

        // Load-use
        idle(); cycle(); cycle(); cycle();
        set_lane(0, 1, 1, 2, 9, 1, 1);
        cycle();
        idle(); set_lane(0, 1, 9, 2, 10, 1, 0);
        settle();
        check("lu stall", stall_out, 1);
        check("lu count before", stall_cycles, 0);
        check("lu sel1 ex", fwd_sel1[0 +: SW], 1);
        cycle(); settle();
        check("lu stall cleared", stall_out, 0);
        check("lu sel1 mem", fwd_sel1[0 +: SW], 3);
        check("lu count after", stall_cycles, 1);
        cycle();

        // x0 and intra-bundle hazard
        idle(); set_lane(0, 1, 1, 2, 0, 1, 0);
        cycle();
        idle(); set_lane(0, 1, 1, 2, 0, 1, 0); set_lane(1, 1, 0, 0, 3, 1, 0);
        settle();
        check("x0 sel1[1]", fwd_sel1[SW +: SW], 0);
        check("x0 sel2[1]", fwd_sel2[SW +: SW], 0);
        check("x0 mask", issue_mask, 2'b11);
        idle(); set_lane(0, 1, 1, 2, 4, 1, 0); set_lane(1, 1, 8, 4, 6, 1, 0);
        settle();
        check("bundle mask", issue_mask, 2'b01);
        cycle();
        idle(); set_lane(1, 1, 6, 4, 0, 0, 0);
        settle();
        check("masked lane1 not recorded", fwd_sel1[SW +: SW], 0);
        check("lane0 recorded", fwd_sel2[SW +: SW], 1);

        // Hold and flush
        idle(); cycle(); cycle(); cycle();
        set_lane(0, 1, 1, 2, 12, 1, 1);
        cycle();
        pipe_hold = 1'b1; flush = 1'b1;
        idle(); set_lane(0, 1, 12, 2, 13, 1, 0);
        for (int i = 0; i < 3; i++) begin
            settle();
            check("hold sel1[0]", fwd_sel1[0 +: SW], 1);
            check("hold stall", stall_out, 1);
            check("hold count", stall_cycles, 1);
            cycle();
        end
        settle();
        check("hold end sel1[0]", fwd_sel1[0 +: SW], 1);
        pipe_hold = 1'b0;
        cycle();
        flush = 1'b0;
        settle();
        check("flush sel1[0]", fwd_sel1[0 +: SW], 3);
        check("flush stall", stall_out, 0);
        check("flush count", stall_cycles, 1);
        cycle();

        // Mixed traffic checked by the model
        for (int i = 0; i < 40; i++) begin
            pipe_hold = ($urandom_range(7, 0) == 0);
            flush     = ($urandom_range(7, 0) == 0);
            for (int l = 0; l < L; l++)
                set_lane(l, bit'($urandom_range(1, 0)), int'($urandom_range(7, 0)),
                         int'($urandom_range(7, 0)), int'($urandom_range(7, 0)),
                         bit'($urandom_range(1, 0)), bit'($urandom_range(1, 0)));
            cycle();
        end
        pipe_hold = 1'b0; flush = 1'b0;

        // Reset mid-run with every stage populated
        idle(); cycle(); cycle(); cycle();
        for (int i = 0; i < 3; i++) begin
            idle(); set_lane(0, 1, 1, 2, 20 + i, 1, 0); set_lane(1, 1, 1, 2, 24 + i, 1, 0);
            cycle();
        end
        idle(); set_lane(0, 1, 20, 26, 0, 0, 0);
        settle();
        check("full sel1[0]", fwd_sel1[0 +: SW], 5);
        check("full sel2[0]", fwd_sel2[0 +: SW], 2);
        reset = 1'b1;
        cycle(); settle();
        check("mid rst sel1", fwd_sel1, 0);
        check("mid rst sel2", fwd_sel2, 0);
        check("mid rst stall", stall_out, 0);
        check("mid rst count", stall_cycles, 0);
        check("mid rst mask", issue_mask, 2'b01);
        reset = 1'b0;
        cycle(); cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end

endmodule
